// File: rtl/wait_state_memory.sv
// ============================================================================
// Module   : wait_state_memory
// Purpose  : Unified word RAM behind a valid/ready port with a fixed response
//            latency, per-byte write lanes and alignment/range error reporting.
// Options  : MEM_RANGE_CHECK_EN - fault addresses outside the mapped window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wait_state_memory #(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 64,
    parameter int                ADDR_W    = 32,
    parameter int                LATENCY   = 1,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_reqValid,
    output logic                  o_reqReady,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic                  i_writeEnable,
    input  logic [DATA_W/8-1:0]   i_byteEnable,
    input  logic [DATA_W-1:0]     i_writeData,
    output logic                  o_rspValid,
    output logic [DATA_W-1:0]     o_readData,
    output logic                  o_rspErr
);

    localparam int c_LANES = DATA_W / 8;
    localparam int c_OFF_W = $clog2(c_LANES);
    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;

    logic [c_IDX_W-1:0]   req_idx_q;
    logic                 req_we_q;
    logic [c_LANES-1:0]   req_be_q;
    logic [DATA_W-1:0]    req_wd_q;
    logic                 req_err_q;

    logic [DATA_W-1:0]    rdata_q;
    logic                 rsp_err_q;
    logic [DATA_W-1:0]    mem_q [DEPTH];

    logic                 w_accept;
    logic                 w_misaligned;
    logic                 w_out_of_range;
    logic                 w_req_err;
    logic [c_IDX_W-1:0]   w_idx_live;
    logic                 w_exec;
    logic                 w_from_wait;
    logic [c_IDX_W-1:0]   w_exec_idx;
    logic                 w_exec_we;
    logic [c_LANES-1:0]   w_exec_be;
    logic [DATA_W-1:0]    w_exec_wd;
    logic                 w_exec_err;
    logic                 w_unused_addr;

    assign w_idx_live    = i_addr[c_OFF_W +: c_IDX_W];
    assign w_unused_addr = ^i_addr;

    generate
        if (c_OFF_W > 0) begin : g_offset
            assign w_misaligned = |i_addr[c_OFF_W-1:0];
        end else begin : g_no_offset
            assign w_misaligned = 1'b0;
        end
    endgenerate

`ifdef MEM_RANGE_CHECK_EN
    localparam logic [ADDR_W:0] c_LIMIT = {1'b0, BASE_ADDR} + (ADDR_W+1)'(DEPTH * c_LANES);
    assign w_out_of_range = (i_addr < BASE_ADDR) || ({1'b0, i_addr} >= c_LIMIT);
`else
    assign w_out_of_range = 1'b0;
`endif

    assign w_req_err  = w_misaligned || w_out_of_range;
    assign o_reqReady = i_rst_n && (state_q != S_WAIT);
    assign w_accept   = i_reqValid && o_reqReady;
    assign o_rspValid = (state_q == S_RESP);
    assign o_readData = rdata_q;
    assign o_rspErr   = rsp_err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = c_CNT_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // With LATENCY == 1 the request executes on its own acceptance edge, so
    // the live inputs are used; after a wait the captured copy is used.
    assign w_exec      = (state_d == S_RESP);
    assign w_from_wait = (state_q == S_WAIT);
    assign w_exec_idx  = w_from_wait ? req_idx_q : w_idx_live;
    assign w_exec_we   = w_from_wait ? req_we_q  : i_writeEnable;
    assign w_exec_be   = w_from_wait ? req_be_q  : i_byteEnable;
    assign w_exec_wd   = w_from_wait ? req_wd_q  : i_writeData;
    assign w_exec_err  = w_from_wait ? req_err_q : w_req_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            req_idx_q <= '0;
            req_we_q  <= 1'b0;
            req_be_q  <= '0;
            req_wd_q  <= '0;
            req_err_q <= 1'b0;
            rdata_q   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                req_idx_q <= w_idx_live;
                req_we_q  <= i_writeEnable;
                req_be_q  <= i_byteEnable;
                req_wd_q  <= i_writeData;
                req_err_q <= w_req_err;
            end
            if (w_exec) begin
                rsp_err_q <= w_exec_err;
                rdata_q   <= (w_exec_we || w_exec_err) ? '0 : mem_q[w_exec_idx];
            end
        end
    end

    // Storage is deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge i_clk) begin
        if (w_exec && w_exec_we && !w_exec_err) begin
            for (int b = 0; b < c_LANES; b++) begin
                if (w_exec_be[b]) begin
                    mem_q[w_exec_idx][8*b +: 8] <= w_exec_wd[8*b +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wait_state_memory.sv
// ============================================================================
// Module   : tb_wait_state_memory
// Purpose  : Scoreboard bench for wait_state_memory at LATENCY 1 and 3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wait_state_memory;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n   [2];
    logic        v       [2];
    logic        rdy     [2];
    logic [31:0] addr    [2];
    logic        we      [2];
    logic [3:0]  be      [2];
    logic [31:0] wd      [2];
    logic        rv      [2];
    logic [31:0] rd      [2];
    logic        re      [2];

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wait_state_memory #(.LATENCY(1)) u_lat1 (
        .i_clk(clk), .i_rst_n(rst_n[0]), .i_reqValid(v[0]), .o_reqReady(rdy[0]),
        .i_addr(addr[0]), .i_writeEnable(we[0]), .i_byteEnable(be[0]),
        .i_writeData(wd[0]), .o_rspValid(rv[0]), .o_readData(rd[0]), .o_rspErr(re[0])
    );

    wait_state_memory #(.LATENCY(3)) u_lat3 (
        .i_clk(clk), .i_rst_n(rst_n[1]), .i_reqValid(v[1]), .o_reqReady(rdy[1]),
        .i_addr(addr[1]), .i_writeEnable(we[1]), .i_byteEnable(be[1]),
        .i_writeData(wd[1]), .o_rspValid(rv[1]), .o_readData(rd[1]), .o_rspErr(re[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response strobe pops one expectation and checks data, error and cycle.
    task automatic mon(input int p);
        exp_t e;
        ntests++;
        if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            nfail++;
            $display("FAIL rsp%0d_unexpected: response at cycle %0d data %h with none pending", p, cyc, rd[p]);
            return;
        end
        e = (p == 0) ? q0.pop_front() : q1.pop_front();
        if (rd[p] !== e.data || re[p] !== e.err || cyc != e.cyc) begin
            nfail++;
            $display("FAIL rsp%0d: got data %h err %b cyc %0d, expected data %h err %b cyc %0d",
                     p, rd[p], re[p], cyc, e.data, e.err, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (rst_n[p] === 1'b1 && rv[p] === 1'b1) mon(p);
        end
    end

    task automatic req(input int p, input logic [31:0] a, input logic w, input logic [3:0] m,
                       input logic [31:0] d, input logic [31:0] ed, input logic ee,
                       input bit expect_rsp, output int acc);
        exp_t e;
        int   n;
        n       = 0;
        v[p]    = 1'b1;
        addr[p] = a;
        we[p]   = w;
        be[p]   = m;
        wd[p]   = d;
        while (rdy[p] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            ntests++;
            nfail++;
            $display("FAIL req%0d_timeout: ready %b after %0d cycles, expected 1", p, rdy[p], n);
            acc = -1;
            return;
        end
        acc = cyc + 1;
        if (expect_rsp) begin
            e.data = ed;
            e.err  = ee;
            e.cyc  = acc + ((p == 0) ? 1 : 3) - 1;
            if (p == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int p, input int n);
        v[p] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int a1, a2, a3;
        for (int p = 0; p < 2; p++) begin
            rst_n[p] = 1'b1; v[p] = 1'b0; addr[p] = '0; we[p] = 1'b0; be[p] = '0; wd[p] = '0;
        end
        #1;
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("reset%0d_ready", p), {31'b0, rdy[p]}, 32'd1);
            chk($sformatf("reset%0d_valid", p), {31'b0, rv[p]},  32'd0);
            chk($sformatf("reset%0d_rdata", p), rd[p],           32'd0);
            chk($sformatf("reset%0d_err", p),   {31'b0, re[p]},  32'd0);
        end

        // LATENCY 1: full write/read, partial lanes, misalignment, empty mask.
        req(0, 32'h10, 1, 4'hF, 32'hDEADBEEF, 32'h0, 0, 1, a1); idle(0, 1);
        req(0, 32'h10, 0, 4'h0, 32'h0, 32'hDEADBEEF, 0, 1, a1); idle(0, 1);
        req(0, 32'h20, 1, 4'hF, 32'h11223344, 32'h0, 0, 1, a1); idle(0, 1);
        req(0, 32'h20, 1, 4'b0010, 32'h0000AA00, 32'h0, 0, 1, a1); idle(0, 1);
        req(0, 32'h20, 0, 4'h0, 32'h0, 32'h1122AA44, 0, 1, a1); idle(0, 1);
        req(0, 32'h22, 0, 4'hF, 32'h0, 32'h0, 1, 1, a1); idle(0, 1);
        req(0, 32'h21, 1, 4'hF, 32'hFFFFFFFF, 32'h0, 1, 1, a1); idle(0, 1);
        req(0, 32'h20, 0, 4'h0, 32'h0, 32'h1122AA44, 0, 1, a1); idle(0, 1);
        req(0, 32'h20, 1, 4'h0, 32'hFFFFFFFF, 32'h0, 0, 1, a1); idle(0, 1);
        req(0, 32'h20, 0, 4'h0, 32'h0, 32'h1122AA44, 0, 1, a1); idle(0, 1);
        // Back-to-back write then read of the same word.
        req(0, 32'h30, 1, 4'hF, 32'h12345678, 32'h0, 0, 1, a1);
        req(0, 32'h30, 0, 4'h0, 32'h0, 32'h12345678, 0, 1, a2); idle(0, 1);
        chk("b2b_lat1_spacing", a2 - a1, 32'd1);
        req(0, 32'h00, 1, 4'hF, 32'hCAFEF00D, 32'h0, 0, 1, a1); idle(0, 1);
`ifdef MEM_RANGE_CHECK_EN
        req(0, 32'h200, 0, 4'h0, 32'h0, 32'h0, 1, 1, a1); idle(0, 1);
`else
        req(0, 32'h200, 0, 4'h0, 32'h0, 32'hCAFEF00D, 0, 1, a1); idle(0, 1);
`endif

        // LATENCY 3: back-to-back writes and reads with valid held high.
        req(1, 32'h0, 1, 4'hF, 32'h000000A0, 32'h0, 0, 1, a1);
        req(1, 32'h4, 1, 4'hF, 32'h000000A4, 32'h0, 0, 1, a1);
        req(1, 32'h8, 1, 4'hF, 32'h000000A8, 32'h0, 0, 1, a1);
        req(1, 32'h0, 0, 4'h0, 32'h0, 32'h000000A0, 0, 1, a1);
        req(1, 32'h4, 0, 4'h0, 32'h0, 32'h000000A4, 0, 1, a2);
        req(1, 32'h8, 0, 4'h0, 32'h0, 32'h000000A8, 0, 1, a3);
        idle(1, 4);
        chk("b2b_lat3_spacing1", a2 - a1, 32'd3);
        chk("b2b_lat3_spacing2", a3 - a2, 32'd3);

        // Reset one cycle after accepting a write: no response, write dropped.
        req(1, 32'h8, 1, 4'hF, 32'h00000055, 32'h0, 0, 0, a1);
        v[1]     = 1'b0;
        rst_n[1] = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_valid", {31'b0, rv[1]}, 32'd0);
        chk("midrst_rdata", rd[1], 32'd0);
        chk("midrst_err",   {31'b0, re[1]}, 32'd0);
        rst_n[1] = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_valid_after", {31'b0, rv[1]}, 32'd0);
        req(1, 32'h8, 0, 4'h0, 32'h0, 32'h000000A8, 0, 1, a1);
        idle(1, 6);

        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wait_state_memory.md
Name: wait_state_memory

Overview:
- Parametrised unified instruction/data memory for the multi-cycle core; successor to the single-cycle-read word RAM.
- Adds a valid/ready request port, a fixed configurable response latency (wait states), per-byte write enables and an alignment error flag.
- Sits between the multi-cycle controller's memory address/data muxes and the register/IR capture stage.

Parameters:
- DATA_W, 32, data width in bits; multiple of 8.
- DEPTH, 64, number of DATA_W words; power of 2, >= 2.
- ADDR_W, 32, byte-address width.
- LATENCY, 1, cycles from request acceptance to response; integer >= 1.
- BASE_ADDR, 0, byte address of word 0; aligned to DEPTH*DATA_W/8.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_reqValid  in  1  request present
- o_reqReady  out  1  block can accept a request this cycle
- i_addr  in  ADDR_W  byte address
- i_writeEnable  in  1  1 = write, 0 = read
- i_byteEnable  in  DATA_W/8  write lane mask; bit n covers data[8n+7:8n]
- i_writeData  in  DATA_W  write data, lane-aligned
- o_rspValid  out  1  one-cycle response strobe
- o_readData  out  DATA_W  read data; valid when o_rspValid
- o_rspErr  out  1  request faulted; valid when o_rspValid

Behaviour:
- Clocking and reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values:
  - State = IDLE; o_reqReady = 1 once reset is released.
  - o_rspValid = 0, o_readData = 0, o_rspErr = 0.
  - Wait counter = 0.
  - RAM contents are not reset.
- Word index = i_addr[log2(DATA_W/8) +: log2(DEPTH)]. Offset bits = i_addr[log2(DATA_W/8)-1:0].
- Acceptance: a request is accepted on a rising edge where i_reqValid && o_reqReady. All request fields are captured at that edge; inputs are don't-care afterwards.
- o_reqReady = 1 in IDLE and RESP, 0 in WAIT. Back-to-back requests are therefore accepted in RESP.
- FSM:
  - IDLE: on accept, go to RESP if LATENCY == 1; otherwise go to WAIT and load counter = LATENCY-2.
  - WAIT: if counter == 0, go to RESP; else decrement.
  - RESP: o_rspValid = 1 for exactly this cycle. On a new accept, branch as from IDLE; else go to IDLE.
- Latency: if a request is accepted at edge k, o_rspValid is high during the cycle following edge k+LATENCY-1. LATENCY=1 gives the response in the cycle right after acceptance. There is no response backpressure.
- Execution occurs on the edge entering RESP:
  - Read: o_readData <= RAM[index].
  - Write: RAM[index] lanes with byteEnable=1 are updated; other lanes are kept. o_readData <= 0.
  - i_byteEnable is ignored for reads.
  - A write with all enables 0 is legal, leaves memory unchanged and returns o_rspErr = 0.
- Alignment error: if the captured offset bits != 0, o_rspErr = 1, the write is suppressed and o_readData = 0.
- Out-of-range addresses: address bits above the index are ignored (aliasing), unless MEM_RANGE_CHECK_EN is defined.
- Ordering: a read accepted in the RESP cycle of a write to the same word returns the written data, because writes complete before the next request executes.
- Reset mid-operation: the captured request is dropped, a pending write is never performed, outputs return to reset values and no response is issued. RAM contents are kept.
- o_readData and o_rspErr hold their values outside RESP; consumers qualify them with o_rspValid.

Optional Feature:
- Macro: MEM_RANGE_CHECK_EN.
- Defined: a request whose address is outside [BASE_ADDR, BASE_ADDR + DEPTH*DATA_W/8) responds with o_rspErr = 1, o_readData = 0 and no write, at the normal latency. An out-of-range address that is also misaligned still gives a single o_rspErr = 1.
- Not defined: upper address bits are ignored and addresses alias modulo the memory size.

Test Plan:
- Default parameters:
  - Write 0xDEADBEEF to 0x10 with byteEnable 4'hF, then read 0x10 → o_rspValid one cycle after each accept; read returns 0xDEADBEEF, o_rspErr = 0.
  - Preload 0x11223344 at 0x20; write 0x0000AA00 with byteEnable 4'b0010 → read of 0x20 returns 0x1122AA44.
  - Read 0x22 → o_rspErr = 1, o_readData = 0. Write 0xFFFFFFFF to 0x21 → error response, and a read of 0x20 still returns 0x1122AA44.
- LATENCY=3:
  - Hold i_reqValid high for 3 reads of 0x0, 0x4, 0x8 → o_reqReady low for 2 cycles after each accept; o_rspValid at accept+3. Next accept coincides with the RESP cycle; no lost or duplicate responses.
  - Accept a write of 0x55 to 0x8, assert i_rst_n = 0 one cycle later → no o_rspValid is ever issued, outputs are 0, and a later read of 0x8 returns the old value.
- MEM_RANGE_CHECK_EN defined, BASE_ADDR=0x100: read 0x200 → o_rspErr = 1. Read 0x104 → data, no error. Without the macro, a read of 0x200 aliases to word 0 with no error.
